// File: rtl/vm_credit_if.sv
// Handshake/bus bundle between the coin/item decoder, the credit state block and the
// change dispenser.
interface vm_credit_if #(
    parameter int unsigned TOTAL_BITS = 31,
    parameter int unsigned WAIT_BITS  = 32,
    parameter int unsigned NUM_COINS  = 3
) ();
    logic [NUM_COINS-1:0]  coin_valid;
    logic                  buy_valid;
    logic [TOTAL_BITS-1:0] buy_price;
    logic                  return_req;
    logic                  change_ready;
    logic [TOTAL_BITS-1:0] current_total;
    logic [WAIT_BITS-1:0]  wait_time;
    logic                  buy_ack;
    logic                  buy_nack;
    logic                  coin_reject;
    logic                  change_valid;
    logic [TOTAL_BITS-1:0] change_amount;
    logic                  timeout;

    modport master (
        output coin_valid, buy_valid, buy_price, return_req, change_ready,
        input  current_total, wait_time, buy_ack, buy_nack, coin_reject,
               change_valid, change_amount, timeout
    );

    modport slave (
        input  coin_valid, buy_valid, buy_price, return_req, change_ready,
        output current_total, wait_time, buy_ack, buy_nack, coin_reject,
               change_valid, change_amount, timeout
    );
endinterface

// File: rtl/vm_credit_state.sv
// Vending-machine credit/timer controller: takes coins, settles purchases, runs the
// inactivity timer and offers change over a valid/ready handshake.
module vm_credit_state #(
    parameter int unsigned TOTAL_BITS = 31,
    parameter int unsigned WAIT_BITS  = 32,
    parameter int unsigned WAIT_TIME  = 100,
    parameter int unsigned NUM_COINS  = 3,
    parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALS = {31'd1000, 31'd500, 31'd100}
) (
    input logic        clk,
    input logic        reset,
    vm_credit_if.slave bus
);
    localparam logic [WAIT_BITS-1:0] WaitReload = WAIT_BITS'(WAIT_TIME);
    localparam logic [WAIT_BITS-1:0] WaitOne    = WAIT_BITS'(1);

    typedef enum logic [1:0] {StIdle, StActive, StReturn} state_e;

    state_e                state;
    logic [TOTAL_BITS-1:0] total;
    logic [WAIT_BITS-1:0]  wait_cnt;
    logic                  buy_ack, buy_nack, coin_reject, timeout;
    logic                  change_valid;
    logic [TOTAL_BITS-1:0] change_amount;

    logic                  coin_any, coin_one, coin_fit, buy_ok;
    logic [TOTAL_BITS-1:0] coin_value, granted, remain;
    logic [TOTAL_BITS:0]   coin_sum;

    // Buy is judged against the pre-coin credit; the coin must fit after the buy settles.
    always_comb begin
        coin_any   = |bus.coin_valid;
        coin_one   = coin_any &&
                     ((bus.coin_valid & (bus.coin_valid - NUM_COINS'(1))) == '0);
        coin_value = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (bus.coin_valid[i]) begin
                coin_value = coin_value | COIN_VALS[i*TOTAL_BITS +: TOTAL_BITS];
            end
        end
        buy_ok   = bus.buy_valid && (bus.buy_price <= total);
        granted  = buy_ok ? bus.buy_price : '0;
        remain   = total - granted;
        coin_sum = {1'b0, remain} + {1'b0, coin_value};
        coin_fit = coin_one && !coin_sum[TOTAL_BITS];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            total         <= '0;
            wait_cnt      <= '0;
            buy_ack       <= 1'b0;
            buy_nack      <= 1'b0;
            coin_reject   <= 1'b0;
            timeout       <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
        end else begin
            buy_ack     <= 1'b0;
            buy_nack    <= 1'b0;
            coin_reject <= 1'b0;
            timeout     <= 1'b0;
            unique case (state)
                StIdle: begin
                    buy_nack <= bus.buy_valid;
                    if (coin_fit) begin
                        total    <= coin_sum[TOTAL_BITS-1:0];
                        wait_cnt <= WaitReload;
                        state    <= StActive;
                    end else begin
                        coin_reject <= coin_any;
                    end
                end
                StActive: begin
                    if (bus.return_req) begin
                        coin_reject   <= coin_any;
                        buy_nack      <= bus.buy_valid;
                        wait_cnt      <= '0;
                        change_valid  <= 1'b1;
                        change_amount <= total;
                        state         <= StReturn;
                    end else begin
                        buy_ack     <= buy_ok;
                        buy_nack    <= bus.buy_valid && !buy_ok;
                        coin_reject <= coin_any && !coin_fit;
                        total       <= coin_fit ? coin_sum[TOTAL_BITS-1:0] : remain;
                        if (buy_ok || coin_fit) begin
                            wait_cnt <= WaitReload;
                        end else if (wait_cnt == WaitOne) begin
                            // No grant and no coin here, so the credit is unchanged.
                            wait_cnt      <= '0;
                            timeout       <= 1'b1;
                            change_valid  <= 1'b1;
                            change_amount <= total;
                            state         <= StReturn;
                        end else if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - WaitOne;
                        end
                    end
                end
                StReturn: begin
                    coin_reject <= coin_any;
                    buy_nack    <= bus.buy_valid;
                    wait_cnt    <= '0;
                    if (change_valid && bus.change_ready) begin
                        total         <= '0;
                        change_valid  <= 1'b0;
                        change_amount <= '0;
                        state         <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.current_total = total;
    assign bus.wait_time     = wait_cnt;
    assign bus.buy_ack       = buy_ack;
    assign bus.buy_nack      = buy_nack;
    assign bus.coin_reject   = coin_reject;
    assign bus.timeout       = timeout;
    assign bus.change_valid  = change_valid;
    assign bus.change_amount = change_amount;
endmodule

// File: tb/tb_vm_credit_state.sv
// Scoreboard bench for vm_credit_state: a 31-bit instance for the main flows and a
// 10-bit instance for the overflow guard.
module tb_vm_credit_state;
    localparam logic [4:0] FAck  = 5'b10000;
    localparam logic [4:0] FNack = 5'b01000;
    localparam logic [4:0] FRej  = 5'b00100;
    localparam logic [4:0] FTo   = 5'b00010;
    localparam logic [4:0] FCv   = 5'b00001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned cyc_cnt = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    vm_credit_if #(.TOTAL_BITS(31), .WAIT_BITS(32), .NUM_COINS(3)) bus_a ();
    vm_credit_if #(.TOTAL_BITS(10), .WAIT_BITS(8), .NUM_COINS(3)) bus_b ();

    vm_credit_state #(
        .TOTAL_BITS(31), .WAIT_BITS(32), .WAIT_TIME(4), .NUM_COINS(3),
        .COIN_VALS({31'd1000, 31'd500, 31'd100})
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    vm_credit_state #(
        .TOTAL_BITS(10), .WAIT_BITS(8), .WAIT_TIME(4), .NUM_COINS(3),
        .COIN_VALS({10'd1000, 10'd500, 10'd100})
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct {
        int unsigned cyc;
        bit          d;
        string       name;
        int unsigned tot;
        int unsigned wt;
        logic [4:0]  fl;
        int unsigned amt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int unsigned g_tot, g_wt, g_amt;
    logic [4:0] g_fl;

    // Monitor: pops every expectation due by this cycle and compares it with the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            m_e = sb.pop_front();
            if (!m_e.d) begin
                g_tot = bus_a.current_total;
                g_wt  = bus_a.wait_time;
                g_amt = bus_a.change_amount;
                g_fl  = {bus_a.buy_ack, bus_a.buy_nack, bus_a.coin_reject,
                         bus_a.timeout, bus_a.change_valid};
            end else begin
                g_tot = 32'(bus_b.current_total);
                g_wt  = 32'(bus_b.wait_time);
                g_amt = 32'(bus_b.change_amount);
                g_fl  = {bus_b.buy_ack, bus_b.buy_nack, bus_b.coin_reject,
                         bus_b.timeout, bus_b.change_valid};
            end
            n_cmp++;
            if (m_e.cyc != cyc_cnt || g_tot != m_e.tot || g_wt != m_e.wt || g_fl !== m_e.fl ||
                (m_e.fl[0] && g_amt != m_e.amt)) begin
                n_err++;
                $display("FAIL %s: got total=%0d wait=%0d ack/nack/rej/to/cv=%b amt=%0d; want total=%0d wait=%0d ack/nack/rej/to/cv=%b amt=%0d",
                         m_e.name, g_tot, g_wt, g_fl, g_amt, m_e.tot, m_e.wt, m_e.fl, m_e.amt);
            end
        end
    end

    task automatic push(input int unsigned cyc, input bit d, input string name,
                        input int unsigned tot, input int unsigned wt, input logic [4:0] fl,
                        input int unsigned amt);
        exp_t e;
        e.cyc = cyc; e.d = d; e.name = name; e.tot = tot; e.wt = wt; e.fl = fl; e.amt = amt;
        sb.push_back(e);
    endtask

    task automatic drive(input bit d, input logic [2:0] coin, input bit buy,
                         input int unsigned price, input bit ret, input bit rdy);
        bus_a.coin_valid = '0; bus_a.buy_valid = 1'b0; bus_a.buy_price = '0;
        bus_a.return_req = 1'b0; bus_a.change_ready = 1'b0;
        bus_b.coin_valid = '0; bus_b.buy_valid = 1'b0; bus_b.buy_price = '0;
        bus_b.return_req = 1'b0; bus_b.change_ready = 1'b0;
        if (!d) begin
            bus_a.coin_valid = coin; bus_a.buy_valid = buy; bus_a.buy_price = 31'(price);
            bus_a.return_req = ret; bus_a.change_ready = rdy;
        end else begin
            bus_b.coin_valid = coin; bus_b.buy_valid = buy; bus_b.buy_price = 10'(price);
            bus_b.return_req = ret; bus_b.change_ready = rdy;
        end
    endtask

    // Called at a falling edge: drive for the next rising edge, expect its result.
    task automatic step(input bit d, input logic [2:0] coin, input bit buy,
                        input int unsigned price, input bit ret, input bit rdy,
                        input string name, input int unsigned tot, input int unsigned wt,
                        input logic [4:0] fl, input int unsigned amt);
        drive(d, coin, buy, price, ret, rdy);
        push(cyc_cnt + 1, d, name, tot, wt, fl, amt);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        step(0, 3'b000, 0, 0, 0, 0, "reset_state_a", 0, 0, 5'b0, 0);
        step(1, 3'b000, 0, 0, 0, 0, "reset_state_b", 0, 0, 5'b0, 0);
        reset = 1'b0;

        // Coin then timeout.
        step(0, 3'b010, 0, 0, 0, 0, "coin500",    500, 4, 5'b0, 0);
        step(0, 3'b000, 0, 0, 0, 0, "tick3",      500, 3, 5'b0, 0);
        step(0, 3'b000, 0, 0, 0, 0, "tick2",      500, 2, 5'b0, 0);
        step(0, 3'b000, 0, 0, 0, 0, "tick1",      500, 1, 5'b0, 0);
        step(0, 3'b000, 0, 0, 0, 1, "expire",     500, 0, FTo | FCv, 500);
        step(0, 3'b000, 0, 0, 0, 1, "handshake",  0,   0, 5'b0, 0);

        // Exact and failed buy.
        step(0, 3'b100, 0, 0,    0, 0, "coin1000",   1000, 4, 5'b0, 0);
        step(0, 3'b010, 0, 0,    0, 0, "coin500_b",  1500, 4, 5'b0, 0);
        step(0, 3'b000, 1, 1500, 0, 0, "buy_exact",  0,    4, FAck, 0);
        step(0, 3'b000, 1, 100,  0, 0, "buy_short",  0,    3, FNack, 0);
        step(0, 3'b000, 0, 0,    1, 0, "ret_zero",   0,    0, FCv, 0);
        step(0, 3'b000, 0, 0,    0, 1, "hs_zero",    0,    0, 5'b0, 0);

        // Simultaneous coin and buy.
        step(0, 3'b001, 0, 0,   0, 0, "coin100",      100,  4, 5'b0, 0);
        step(0, 3'b100, 1, 100, 0, 0, "coin_buy_ack", 1000, 4, FAck, 0);
        step(0, 3'b000, 1, 900, 0, 0, "buy900",       100,  4, FAck, 0);
        step(0, 3'b100, 1, 600, 0, 0, "coin_buy_nak", 1100, 4, FNack, 0);
        step(0, 3'b000, 1, 500, 0, 0, "buy500",       600,  4, FAck, 0);

        // Return has priority over coin and buy.
        step(0, 3'b001, 1, 100, 1, 0, "ret_prio",  600, 0, FRej | FNack | FCv, 600);
        step(0, 3'b000, 0, 0,   0, 0, "hold1",     600, 0, FCv, 600);
        step(0, 3'b000, 0, 0,   0, 0, "hold2",     600, 0, FCv, 600);
        step(0, 3'b001, 1, 100, 1, 0, "hold3_rej", 600, 0, FRej | FNack | FCv, 600);
        step(0, 3'b000, 0, 0,   0, 0, "hold4",     600, 0, FCv, 600);
        step(0, 3'b000, 0, 0,   0, 0, "hold5",     600, 0, FCv, 600);

        // Asynchronous reset between edges while change is offered.
        @(posedge clk);
        #2;
        reset = 1'b1;
        push(cyc_cnt, 0, "async_reset", 0, 0, 5'b0, 0);
        @(negedge clk);
        step(0, 3'b000, 0, 0, 0, 1, "reset_held", 0, 0, 5'b0, 0);
        reset = 1'b0;
        step(0, 3'b000, 0, 0, 1, 0, "idle_ret_ignored", 0, 0, 5'b0, 0);
        step(0, 3'b000, 1, 0, 0, 0, "idle_buy_nack",    0, 0, FNack, 0);
        step(0, 3'b011, 0, 0, 0, 0, "idle_multihot",    0, 0, FRej, 0);

        // Overflow guard on the 10-bit instance.
        step(1, 3'b100, 0, 0,    0, 0, "b_coin1000",    1000, 4, 5'b0, 0);
        step(1, 3'b001, 0, 0,    0, 0, "b_overflow",    1000, 3, FRej, 0);
        step(1, 3'b011, 0, 0,    0, 0, "b_multihot",    1000, 2, FRej, 0);
        step(1, 3'b100, 1, 1000, 0, 0, "b_buy_coin",    1000, 4, FAck, 0);
        step(1, 3'b001, 1, 77,   0, 0, "b_fill_to_max", 1023, 4, FAck, 0);

        drive(0, 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
